// File: rtl/bk_byte_serial_adder.sv
// rtl/bk_byte_serial_adder.sv - byte-serial multi-precision add/sub sequencer
// Drives an external combinational 8-bit adder LSB byte first, chaining carry between bytes.
module bk_byte_serial_adder #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic         op_sub,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [NBYTES-1:0][7:0] a_reg;
  logic [NBYTES-1:0][7:0] b_reg;
  logic [NBYTES-1:0][7:0] sum_reg;
  logic                   c_reg;
  logic [IW-1:0]          idx;
  logic                   cout_reg;
  logic                   ovf_reg;
  logic                   accept;
  logic                   last;

  // DONE can hand straight over to RUN when the consumer drains the result this cycle
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == LAST_IDX);

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[idx];
        add_b   = b_reg[idx];
        add_cin = c_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      c_reg    <= 1'b0;
      idx      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= op_a;
        b_reg <= op_sub ? ~op_b : op_b;
        c_reg <= op_sub ? 1'b1 : op_cin;
        idx   <= '0;
      end else if (state == RUN) begin
        sum_reg[idx] <= add_s;
        c_reg        <= add_cout;
        if (last) begin
          idx      <= '0;
          cout_reg <= add_cout;
          // carry into the MSB is recovered from the MSB sum bit and its operand bits
          ovf_reg  <= add_cout ^ (a_reg[NBYTES-1][7] ^ b_reg[NBYTES-1][7] ^ add_s[7]);
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bk_byte_serial_adder.sv
// tb/tb_bk_byte_serial_adder.sv - scoreboard bench for bk_byte_serial_adder
// Stimulus pushes reference results at accept; an independent monitor pops them on out_valid&&out_ready.
module tb_bk_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         op_sub = 1'b0;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   prev_ov = 0;
  bit   rnd_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external 8-bit adder stand-in
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  bk_byte_serial_adder #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .op_sub   (op_sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full;
    longint sres;
    if (sub) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      e.c  = (full >= 64'sh1_0000_0000);
      sres = sa + sb + longint'(cin);
    end
    e.s = full[W-1:0];
    e.v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit ok = 0;
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        lat_q.push_back(cyc + 1);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  // Returns at a falling edge with out_valid high (or after the bound expires).
  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    chk("valid_timeout", 64'(ok), 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each out_valid rise, result on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        chk("unexpected_valid", 64'(lat_q.size() != 0), 64'd1);
        if (lat_q.size() != 0) chk("latency", 64'(cyc - lat_q.pop_front()), 64'(NB));
      end
      if (out_valid && out_ready) begin
        chk("unexpected_result", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_sum", 64'(sum), 64'(e.s));
          chk("sb_cout", 64'(cout), 64'(e.c));
          chk("sb_ovf", 64'(ovf), 64'(e.v));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] av;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_sum", 64'(sum), 64'd0);
      chk("idle_add_a", 64'(add_a), 64'd0);
    end
    tick();

    // full ripple: per-byte operands and carry chain
    av = 32'hFFFF_FFFF;
    send(av, 32'h0000_0001, 1'b0, 1'b0);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk("ripple_add_a", 64'(add_a), 64'(av[8*k+:8]));
      chk("ripple_add_cin", 64'(add_cin), 64'(k != 0));
    end
    wait_valid();
    chk("ripple_sum", 64'(sum), 64'h0);
    chk("ripple_cout", 64'(cout), 64'd1);
    chk("ripple_ovf", 64'(ovf), 64'd0);
    tick();

    // subtraction cases
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    wait_valid();
    chk("sub1_sum", 64'(sum), 64'hFFFF_FFFE);
    chk("sub1_cout_ovf", 64'({cout, ovf}), 64'b00);
    tick();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    wait_valid();
    chk("sub2_sum", 64'(sum), 64'h7FFF_FFFF);
    chk("sub2_cout_ovf", 64'({cout, ovf}), 64'b11);
    tick();

    // backpressure then back-to-back
    out_ready = 1'b0;
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sum", 64'(sum), 64'h1010_1010);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    tick();
    out_ready = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_running", 64'({out_valid, in_ready}), 64'b00);
    wait_valid();
    chk("b2b_sum", 64'(sum), 64'h2345_6789);
    tick();

    // reset mid-operation
    send(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tick();
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_add", 64'({add_a, add_b, add_cin}), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    tick();
    send(32'd2, 32'd3, 1'b0, 1'b0);
    wait_valid();
    chk("after_abort_sum", 64'(sum), 64'd5);
    tick();

    // operand changes after accept are ignored
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    op_a = 32'hDEAD_BEEF;
    op_b = 32'hCAFE_F00D;
    op_sub = 1'b1;
    wait_valid();
    chk("captured_sum", 64'(sum), 64'h3333_3333);
    tick();
    send(32'd0, 32'd0, 1'b1, 1'b0);
    wait_valid();
    chk("cin_sum", 64'(sum), 64'd1);
    tick();

    // randomized traffic with random backpressure
    rnd_en = 1;
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 10 == 0) ra = 32'h7FFF_FFFF;
      if (n % 10 == 5) rb = 32'h8000_0000;
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        op_a = $urandom;
        op_b = $urandom;
        op_sub = ~op_sub;
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_en = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

endmodule
